mul24_share_ctrl: RTL and testbench

MUL24_SHARE_CTRL -- requirements
Module: mul24_share_ctrl

---
 rtl/mul24_share_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mul24_share_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul24_share_ctrl.sv
// rtl/mul24_share_ctrl.sv - two-requester front end for a shared 24x24 multiplier
//
// Purpose:
//   Arbitrates two requesters onto one fixed-latency multiplier datapath.
//   Each requester has a small response FIFO. Per-requester credits
//   (free slots minus operations still in flight) ensure that every product
//   coming back has a free slot waiting for it, so the datapath never stalls.
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   reqN_valid/ready/a/b      operand handshake for requester N (N = 0, 1)
//   rspN_valid/ready/p        product handshake for requester N, head of its FIFO
//   mul_a, mul_b, mul_go      registered operands issued to the shared datapath
//   mul_p                     datapath product, valid LAT cycles after mul_go
//   busy                      an operation is in flight or a FIFO holds data
module mul24_share_ctrl #(
  parameter int LAT   = 3,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [23:0] req0_a,
  input  logic [23:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [23:0] req1_a,
  input  logic [23:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [47:0] rsp0_p,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [47:0] rsp1_p,
  output logic [23:0] mul_a,
  output logic [23:0] mul_b,
  output logic        mul_go,
  input  logic [47:0] mul_p,
  output logic        busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [23:0] req_a [2];
  logic [23:0] req_b [2];

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_a[0]  = req0_a;
  assign req_a[1]  = req1_a;
  assign req_b[0]  = req0_b;
  assign req_b[1]  = req1_b;

  // Round-robin pointer: the requester preferred when both are eligible.
  logic ptr_q, ptr_d;

  // Issue register: operands and owner of the op presented on mul_go.
  logic        mul_go_q, mul_go_d;
  logic        issue_id_q, issue_id_d;
  logic [23:0] mul_a_q, mul_a_d;
  logic [23:0] mul_b_q, mul_b_d;

  // Tag pipeline follows the datapath; stage LAT-1 lines up with mul_p.
  logic [LAT-1:0] tag_v_q, tag_v_d;
  logic [LAT-1:0] tag_id_q, tag_id_d;

  // Response FIFOs.
  logic [47:0]   buf_q [2][DEPTH];
  logic [47:0]   buf_d [2][DEPTH];
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] wr_ptr_d [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [PW-1:0] rd_ptr_d [2];
  logic [CW-1:0] occ_q [2];
  logic [CW-1:0] occ_d [2];

  logic [3:0] inflight_cnt [2];
  logic [4:0] used [2];
  logic [1:0] elig;
  logic [1:0] grant;
  logic [1:0] rsp_valid_int;
  logic [1:0] push;
  logic [1:0] pop;
  logic       cap_v;
  logic       cap_id;

  always_comb begin
    ptr_d         = ptr_q;
    mul_go_d      = 1'b0;
    issue_id_d    = issue_id_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    tag_v_d       = tag_v_q;
    tag_id_d      = tag_id_q;
    buf_d         = buf_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q;
    inflight_cnt  = '{default: '0};
    used          = '{default: '0};
    elig          = '0;
    grant         = '0;
    rsp_valid_int = '0;
    push          = '0;
    pop           = '0;
    cap_v         = tag_v_q[LAT-1];
    cap_id        = tag_id_q[LAT-1];

    // Credit: slots not yet promised to a buffered or in-flight product.
    for (int r = 0; r < 2; r++) begin
      if (mul_go_q && (issue_id_q == 1'(r))) begin
        inflight_cnt[r] = 4'd1;
      end
      for (int i = 0; i < LAT; i++) begin
        if (tag_v_q[i] && (tag_id_q[i] == 1'(r))) begin
          inflight_cnt[r] = inflight_cnt[r] + 4'd1;
        end
      end
      used[r] = 5'(occ_q[r]) + 5'(inflight_cnt[r]);
      elig[r] = rst && req_valid[r] && (used[r] < 5'(DEPTH));
    end

    grant[0] = elig[0] && (!elig[1] || !ptr_q);
    grant[1] = elig[1] && (!elig[0] ||  ptr_q);

    if (|grant) begin
      // Preference passes to the requester that just lost (or did not ask).
      ptr_d      = grant[0];
      mul_go_d   = 1'b1;
      issue_id_d = grant[1];
      mul_a_d    = grant[1] ? req_a[1] : req_a[0];
      mul_b_d    = grant[1] ? req_b[1] : req_b[0];
    end

    tag_v_d[0]  = mul_go_q;
    tag_id_d[0] = issue_id_q;
    for (int i = 1; i < LAT; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end

    for (int r = 0; r < 2; r++) begin
      rsp_valid_int[r] = rst && (occ_q[r] != '0);
      push[r]          = cap_v && (cap_id == 1'(r));
      pop[r]           = rsp_valid_int[r] && rsp_ready[r];
      if (push[r]) begin
        buf_d[r][wr_ptr_q[r]] = mul_p;
        wr_ptr_d[r]           = wr_ptr_q[r] + PW'(1);
      end
      if (pop[r]) begin
        rd_ptr_d[r] = rd_ptr_q[r] + PW'(1);
      end
      occ_d[r] = occ_q[r] + CW'(push[r]) - CW'(pop[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q      <= 1'b0;
      mul_go_q   <= 1'b0;
      issue_id_q <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      tag_v_q    <= '0;
      tag_id_q   <= '0;
      wr_ptr_q   <= '{default: '0};
      rd_ptr_q   <= '{default: '0};
      occ_q      <= '{default: '0};
    end else begin
      ptr_q      <= ptr_d;
      mul_go_q   <= mul_go_d;
      issue_id_q <= issue_id_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      tag_v_q    <= tag_v_d;
      tag_id_q   <= tag_id_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // FIFO storage carries data only; emptiness is defined by occ_q.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = rsp_valid_int[0];
  assign rsp1_valid = rsp_valid_int[1];
  assign rsp0_p     = buf_q[0][rd_ptr_q[0]];
  assign rsp1_p     = buf_q[1][rd_ptr_q[1]];
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_go     = mul_go_q;
  assign busy       = rst && (mul_go_q || (|tag_v_q) || (occ_q[0] != '0) || (occ_q[1] != '0));

endmodule

// File: tb/tb_mul24_share_ctrl.sv
// tb/tb_mul24_share_ctrl.sv - self-checking bench for mul24_share_ctrl
module tb_mul24_share_ctrl;
  localparam int LAT   = 3;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [23:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [47:0] rsp0_p, rsp1_p;
  logic [23:0] mul_a, mul_b;
  logic        mul_go;
  logic [47:0] mul_p;
  logic        busy;

  always #5 clk = ~clk;

  mul24_share_ctrl #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_p(rsp0_p),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_p(rsp1_p),
    .mul_a(mul_a), .mul_b(mul_b), .mul_go(mul_go), .mul_p(mul_p), .busy(busy)
  );

  // Stand-in datapath: product appears LAT cycles after mul_go; noise otherwise.
  logic [47:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= mul_go ? (48'(mul_a) * 48'(mul_b)) : {16'($urandom), 32'($urandom)};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_p = pipe[LAT-1];

  // Reference model: per-requester queues of accepted ops in acceptance order.
  typedef struct {
    logic [47:0] p;
    int          rdy;
  } ent_t;
  ent_t q0[$];
  ent_t q1[$];
  int        cyc = 0;
  bit        ptr_m = 0;
  bit        mvalid = 0;
  logic      mgo = 1'b0;
  logic [23:0] ma = '0, mb = '0;
  int errors = 0;
  int checks = 0;

  logic        s_rst, s_v0, s_v1, s_rr0, s_rr1;
  logic [23:0] s_a0, s_b0, s_a1, s_b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit e0, e1, g0, g1, rv0, rv1;
    ent_t e;
    @(negedge clk);
    rst = s_rst; req0_valid = s_v0; req1_valid = s_v1;
    req0_a = s_a0; req0_b = s_b0; req1_a = s_a1; req1_b = s_b1;
    rsp0_ready = s_rr0; rsp1_ready = s_rr1;
    #1;
    if (!s_rst) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      q0.delete(); q1.delete();
      ptr_m = 0; mgo = 1'b0; ma = '0; mb = '0; mvalid = 1;
    end else begin
      e0 = s_v0 && (q0.size() < DEPTH);
      e1 = s_v1 && (q1.size() < DEPTH);
      g0 = e0 && (!e1 || ptr_m == 0);
      g1 = e1 && (!e0 || ptr_m == 1);
      rv0 = (q0.size() > 0) && (q0[0].rdy <= cyc);
      rv1 = (q1.size() > 0) && (q1[0].rdy <= cyc);
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      chk("rsp0_valid", rsp0_valid, rv0);
      chk("rsp1_valid", rsp1_valid, rv1);
      if (rv0) chk("rsp0_p", rsp0_p, q0[0].p);
      if (rv1) chk("rsp1_p", rsp1_p, q1[0].p);
      if (mvalid) begin
        chk("mul_go", mul_go, mgo);
        chk("mul_a", mul_a, ma);
        chk("mul_b", mul_b, mb);
        chk("busy", busy, (q0.size() + q1.size()) != 0);
      end
      if (rv0 && s_rr0) void'(q0.pop_front());
      if (rv1 && s_rr1) void'(q1.pop_front());
      if (g0) begin
        e.p = 48'(s_a0) * 48'(s_b0); e.rdy = cyc + LAT + 2; q0.push_back(e);
        ma = s_a0; mb = s_b0;
      end
      if (g1) begin
        e.p = 48'(s_a1) * 48'(s_b1); e.rdy = cyc + LAT + 2; q1.push_back(e);
        ma = s_a1; mb = s_b1;
      end
      if (g0 || g1) ptr_m = g0;
      mgo = g0 || g1;
    end
    cyc++;
  endtask

  task automatic idle();
    s_v0 = 0; s_v1 = 0; s_rr0 = 1; s_rr1 = 1;
  endtask

  task automatic do_reset(input int n);
    s_rst = 0;
    for (int i = 0; i < n; i++) cycle();
    s_rst = 1;
  endtask

  int n1;

  initial begin
    s_rst = 0; s_a0 = '0; s_b0 = '0; s_a1 = '0; s_b1 = '0;
    idle();
    do_reset(3);

    // Single op 3 x 5 on requester 0.
    s_v0 = 1; s_a0 = 24'h000003; s_b0 = 24'h000005;
    cycle();
    idle();
    for (int i = 0; i < 8; i++) cycle();

    // Contention from reset: both requesters valid every cycle.
    do_reset(1);
    s_v0 = 1; s_v1 = 1;
    for (int i = 0; i < 16; i++) begin
      s_a0 = 24'($urandom); s_b0 = 24'($urandom);
      s_a1 = 24'($urandom); s_b1 = 24'($urandom);
      cycle();
    end
    idle();
    for (int i = 0; i < 8; i++) cycle();

    // Backpressure on requester 1.
    do_reset(1);
    s_v0 = 1; s_v1 = 1; s_rr0 = 1; s_rr1 = 0; n1 = 0;
    for (int i = 0; i < 14; i++) begin
      s_a0 = 24'($urandom); s_b0 = 24'($urandom);
      s_a1 = 24'($urandom); s_b1 = 24'($urandom);
      cycle();
      if (req1_ready && req1_valid) n1++;
    end
    chk("bp_accept_count", n1, DEPTH);
    s_v0 = 0; s_rr1 = 1;
    cycle();
    s_rr1 = 0;
    cycle();
    chk("bp_ready_after_pop", req1_ready, 1);
    idle();
    for (int i = 0; i < 10; i++) cycle();

    // Max operands queued behind an earlier product of the same requester.
    s_v0 = 1; s_a0 = 24'h000007; s_b0 = 24'h000009;
    cycle();
    s_a0 = 24'hFFFFFF; s_b0 = 24'hFFFFFF;
    cycle();
    s_v0 = 0;
    for (int i = 0; i < 5; i++) cycle();
    chk("max_rsp_valid", rsp0_valid, 1);
    chk("max_rsp_p", rsp0_p, 48'hFFFFFE000001);
    for (int i = 0; i < 4; i++) cycle();

    // Reset with operations in flight; late products must be ignored.
    s_v0 = 1; s_v1 = 1;
    for (int i = 0; i < 3; i++) begin
      s_a0 = 24'($urandom); s_b0 = 24'($urandom);
      s_a1 = 24'($urandom); s_b1 = 24'($urandom);
      cycle();
    end
    idle();
    do_reset(1);
    for (int i = 0; i < 8; i++) cycle();
    chk("post_rst_busy", busy, 0);
    s_v1 = 1; s_a1 = 24'h000101; s_b1 = 24'h000010;
    cycle();
    idle();
    for (int i = 0; i < 8; i++) cycle();

    // Fill requester 0, then stream with push and pop in the same cycles.
    s_v0 = 1; s_rr0 = 0;
    for (int i = 0; i < 8; i++) begin
      s_a0 = 24'($urandom); s_b0 = 24'($urandom);
      cycle();
    end
    s_rr0 = 1;
    for (int i = 0; i < 20; i++) begin
      s_a0 = 24'($urandom); s_b0 = 24'($urandom);
      cycle();
    end
    idle();
    for (int i = 0; i < 8; i++) cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      s_v0 = 1'($urandom_range(0, 1)); s_v1 = 1'($urandom_range(0, 1));
      s_rr0 = ($urandom_range(0, 3) != 0); s_rr1 = ($urandom_range(0, 3) == 0);
      s_a0 = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
      s_b0 = 24'($urandom);
      s_a1 = 24'($urandom);
      s_b1 = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
      cycle();
    end
    idle();
    for (int i = 0; i < 12; i++) cycle();
    chk("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
